// File: rtl/test_tools_pkg.sv
// Shared definitions for the result checker: FSM state encodings and drain length.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package test_tools_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  // Cycles spent in DRAIN so checks still in the compare pipeline are counted.
  localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/test_checker_sat_cnt.sv
// Saturating accumulator: adds a small increment each cycle and sticks at all-ones.
// Latency: one cycle from inc to count.
// Backpressure: none; every increment is accepted, the excess beyond full scale is dropped.
module test_checker_sat_cnt #(
  parameter int WIDTH     = 16,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH:0] sum;

  // One spare bit catches the carry that signals saturation.
  always_comb begin
    sum = {1'b0, count} + (WIDTH+1)'(inc);
  end

  // Clear wins over accumulate; overflow pins the counter at full scale.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (sum[WIDTH]) begin
      count <= '1;
    end else begin
      count <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/test_checker.sv
// Multi-channel result checker with end-of-test FSM (optional watchdog: TEST_CHECKER_WATCHDOG_EN).
// Latency: chk_* registered at one edge, counters/flags updated at the next (visible two edges after drive).
// Backpressure: none; checks are always accepted in RUN and silently dropped in every other state.
module test_checker
  import test_tools_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int FINISH_DELAY   = 100,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          test_start,
  input  logic                                          test_done,
  input  logic                                          test_abort,
  input  logic [NUM_CH-1:0]                             chk_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  chk_value,
  input  logic [NUM_CH*DATA_WIDTH-1:0]                  chk_expected,
  output logic                                          busy,
  output logic                                          test_passed,
  output logic                                          test_failed,
  output logic                                          test_finished,
  output logic                                          timeout,
  output logic [CNT_WIDTH-1:0]                          check_count,
  output logic [CNT_WIDTH-1:0]                          fail_count,
  output logic [NUM_CH-1:0]                             ch_failed,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_fail_ch,
  output logic [DATA_WIDTH-1:0]                         first_fail_value,
  output logic [DATA_WIDTH-1:0]                         first_fail_expected
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int INC_W = $clog2(NUM_CH + 1);
  localparam int FIN_W = $clog2(FINISH_DELAY + 1);

  state_t                       state;
  logic [1:0]                   drain_cnt;
  logic [FIN_W-1:0]             fin_cnt;
  logic                         wd_fire;

  logic [NUM_CH-1:0]            s1_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] s1_value;
  logic [NUM_CH*DATA_WIDTH-1:0] s1_expected;

  logic [NUM_CH-1:0]            mism;
  logic [INC_W-1:0]             inc_chk;
  logic [INC_W-1:0]             inc_fail;
  logic                         ff_hit;
  logic [CH_W-1:0]              ff_idx;
  logic [DATA_WIDTH-1:0]        ff_value;
  logic [DATA_WIDTH-1:0]        ff_expected;
  logic                         ff_seen;

  // Stage 1: capture checks only while RUN so idle/terminal traffic never reaches the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= '0;
      s1_value    <= '0;
      s1_expected <= '0;
    end else if (state == ST_RUN) begin
      s1_valid    <= chk_valid;
      s1_value    <= chk_value;
      s1_expected <= chk_expected;
    end else begin
      s1_valid    <= '0;
    end
  end

  // Stage 2 compare: popcounts and the lowest-index failing channel (descending loop, last write wins).
  always_comb begin
    mism        = '0;
    inc_chk     = '0;
    inc_fail    = '0;
    ff_hit      = 1'b0;
    ff_idx      = '0;
    ff_value    = '0;
    ff_expected = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef SYNTHESIS
      mism[i] = s1_valid[i] && (s1_value[i*DATA_WIDTH +: DATA_WIDTH] != s1_expected[i*DATA_WIDTH +: DATA_WIDTH]);
`else
      // Case inequality so X/Z on either side is reported as a failure.
      mism[i] = s1_valid[i] && (s1_value[i*DATA_WIDTH +: DATA_WIDTH] !== s1_expected[i*DATA_WIDTH +: DATA_WIDTH]);
`endif
      inc_chk  = inc_chk + INC_W'(s1_valid[i]);
      inc_fail = inc_fail + INC_W'(mism[i]);
      if (mism[i]) begin
        ff_hit      = 1'b1;
        ff_idx      = CH_W'(i);
        ff_value    = s1_value[i*DATA_WIDTH +: DATA_WIDTH];
        ff_expected = s1_expected[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  test_checker_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_check_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .inc   (inc_chk),
    .count (check_count)
  );

  test_checker_sat_cnt #(.WIDTH(CNT_WIDTH), .INC_WIDTH(INC_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .inc   (inc_fail),
    .count (fail_count)
  );

  // Sticky per-channel flags and a one-shot capture of the first failing cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_failed           <= '0;
      ff_seen             <= 1'b0;
      first_fail_ch       <= '0;
      first_fail_value    <= '0;
      first_fail_expected <= '0;
    end else begin
      ch_failed <= ch_failed | mism;
      if (ff_hit && !ff_seen) begin
        ff_seen             <= 1'b1;
        first_fail_ch       <= ff_idx;
        first_fail_value    <= ff_value;
        first_fail_expected <= ff_expected;
      end
    end
  end

`ifdef TEST_CHECKER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == ST_RUN) && (chk_valid == '0) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive RUN cycles without any check; fire on the TIMEOUT_CYCLES-th one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == ST_RUN) begin
      if (chk_valid != '0) begin
        wd_cnt <= '0;
      end else if (wd_fire) begin
        timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`else
  // Watchdog compiled out: RUN waits for test_done/test_abort indefinitely.
  assign wd_fire = 1'b0;
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  // End-of-test FSM with registered status outputs and the finish delay counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      test_passed   <= 1'b0;
      test_failed   <= 1'b0;
      test_finished <= 1'b0;
      drain_cnt     <= '0;
      fin_cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (test_start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (test_abort || wd_fire) begin
            state       <= ST_FAIL;
            busy        <= 1'b0;
            test_failed <= 1'b1;
          end else if (test_done) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (test_abort) begin
            state       <= ST_FAIL;
            busy        <= 1'b0;
            test_failed <= 1'b1;
          end else if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
            busy <= 1'b0;
            if (fail_count != '0) begin
              state       <= ST_FAIL;
              test_failed <= 1'b1;
            end else begin
              state       <= ST_PASS;
              test_passed <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_PASS, ST_FAIL: begin
          if (!test_finished) begin
            if (fin_cnt == FIN_W'(FINISH_DELAY - 1)) begin
              test_finished <= 1'b1;
            end else begin
              fin_cnt <= fin_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_checker.sv
// Directed self-checking bench for test_checker (NUM_CH=4, CNT_WIDTH=6 so saturation is reachable).
// Latency: samples 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_test_checker;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          test_start, test_done, test_abort;
  logic [NC-1:0] chk_valid;
  logic [NC*DW-1:0] chk_value, chk_expected;
  logic          busy, test_passed, test_failed, test_finished, timeout;
  logic [CW-1:0] check_count, fail_count;
  logic [NC-1:0] ch_failed;
  logic [1:0]    first_fail_ch;
  logic [DW-1:0] first_fail_value, first_fail_expected;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  test_checker #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .CNT_WIDTH(CW), .FINISH_DELAY(100), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .test_start(test_start), .test_done(test_done), .test_abort(test_abort),
    .chk_valid(chk_valid), .chk_value(chk_value), .chk_expected(chk_expected),
    .busy(busy), .test_passed(test_passed), .test_failed(test_failed),
    .test_finished(test_finished), .timeout(timeout),
    .check_count(check_count), .fail_count(fail_count), .ch_failed(ch_failed),
    .first_fail_ch(first_fail_ch), .first_fail_value(first_fail_value),
    .first_fail_expected(first_fail_expected)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v, input logic [DW-1:0] e);
    chk_value[ch*DW +: DW]    = v;
    chk_expected[ch*DW +: DW] = e;
  endtask

  task automatic drive_match(input logic [NC-1:0] vld);
    for (int i = 0; i < NC; i++) set_ch(i, 32'h1111_0000 + i, 32'h1111_0000 + i);
    chk_valid = vld;
  endtask

  task automatic drive_all_bad();
    for (int i = 0; i < NC; i++) set_ch(i, 32'h2222_0000 + i, 32'h2222_0001 + i);
    chk_valid = 4'hF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; test_start = 1'b0; test_done = 1'b0; test_abort = 1'b0;
    chk_valid = '0; chk_value = '0; chk_expected = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic start_test();
    test_start = 1'b1; tick(); test_start = 1'b0;
  endtask

  task automatic end_test();
    test_done = 1'b1; tick(); test_done = 1'b0; tick(); tick();
  endtask

  initial begin
    // ---- Test 1: reset state, 10 all-match cycles, PASS, finish delay
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_passed", test_passed, 0);
    chk("rst_failed", test_failed, 0);
    chk("rst_finished", test_finished, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_check_count", check_count, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_ch_failed", ch_failed, 0);
    start_test();
    chk("t1_busy_run", busy, 1);
    for (int c = 0; c < 10; c++) begin
      drive_match(4'hF);
      tick();
    end
    chk_valid = '0;
    test_done = 1'b1; tick(); test_done = 1'b0;
    chk("t1_busy_drain", busy, 1);
    tick(); tick();
    chk("t1_passed", test_passed, 1);
    chk("t1_failed", test_failed, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_check_count", check_count, 40);
    chk("t1_fail_count", fail_count, 0);
    repeat (99) tick();
    chk("t1_finished_early", test_finished, 0);
    tick();
    chk("t1_finished", test_finished, 1);
    test_start = 1'b1; test_abort = 1'b1; tick(); test_start = 1'b0; test_abort = 1'b0;
    chk("t1_terminal_pass", test_passed, 1);
    chk("t1_terminal_fail", test_failed, 0);

    // ---- Test 2: single mismatch on ch2 in the third cycle
    do_reset();
    start_test();
    for (int c = 0; c < 5; c++) begin
      drive_match(4'hF);
      if (c == 2) set_ch(2, 32'hDEAD_BEEF, 32'hDEAD_BEE0);
      tick();
    end
    chk_valid = '0;
    end_test();
    chk("t2_failed", test_failed, 1);
    chk("t2_passed", test_passed, 0);
    chk("t2_check_count", check_count, 20);
    chk("t2_fail_count", fail_count, 1);
    chk("t2_ch_failed", ch_failed, 4'b0100);
    chk("t2_first_ch", first_fail_ch, 2);
    chk("t2_first_value", first_fail_value, 32'hDEAD_BEEF);
    chk("t2_first_exp", first_fail_expected, 32'hDEAD_BEE0);

    // ---- Test 3: simultaneous ch1/ch3 mismatch, later ch0 does not recapture, abort beats done
    do_reset();
    start_test();
    drive_match(4'hF);
    set_ch(1, 32'h0000_0011, 32'h0000_0010);
    set_ch(3, 32'h0000_0033, 32'h0000_0030);
    tick();
    drive_match(4'hF);
    set_ch(0, 32'h0000_000A, 32'h0000_000B);
    tick();
    chk("t3_fail_count_a", fail_count, 2);
    chk("t3_check_count_a", check_count, 4);
    chk("t3_first_ch", first_fail_ch, 1);
    chk("t3_first_value", first_fail_value, 32'h11);
    chk("t3_first_exp", first_fail_expected, 32'h10);
    chk("t3_ch_failed_a", ch_failed, 4'b1010);
    chk_valid = '0;
    tick();
    chk("t3_fail_count_b", fail_count, 3);
    chk("t3_first_ch_kept", first_fail_ch, 1);
    chk("t3_first_value_kept", first_fail_value, 32'h11);
    chk("t3_ch_failed_b", ch_failed, 4'b1011);
    test_abort = 1'b1; test_done = 1'b1; tick(); test_abort = 1'b0; test_done = 1'b0;
    chk("t3_abort_failed", test_failed, 1);
    chk("t3_abort_busy", busy, 0);

    // ---- Test 4: check on the same edge as test_done is flushed and counted
    do_reset();
    start_test();
    drive_match(4'b0011);
    test_done = 1'b1; tick(); test_done = 1'b0; chk_valid = '0;
    chk("t4_busy_drain", busy, 1);
    tick(); tick();
    chk("t4_passed", test_passed, 1);
    chk("t4_check_count", check_count, 2);

    // ---- Test 5: reset mid-RUN clears everything; IDLE ignores checks; start beats done
    do_reset();
    start_test();
    drive_all_bad(); tick();
    drive_match(4'h1); set_ch(0, 32'h5, 32'h6); tick();
    chk_valid = '0; tick(); tick();
    chk("t5_fail_count_pre", fail_count, 5);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_fail_count", fail_count, 0);
    chk("t5_rst_check_count", check_count, 0);
    chk("t5_rst_ch_failed", ch_failed, 0);
    chk("t5_rst_first_value", first_fail_value, 0);
    chk("t5_rst_busy", busy, 0);
    drive_all_bad(); tick(); tick(); tick();
    chk("t5_idle_check_count", check_count, 0);
    chk("t5_idle_ch_failed", ch_failed, 0);
    chk_valid = '0;
    test_start = 1'b1; test_done = 1'b1; tick(); test_start = 1'b0; test_done = 1'b0;
    tick(); tick(); tick();
    chk("t5_start_wins_busy", busy, 1);
    chk("t5_start_wins_passed", test_passed, 0);
    end_test();
    chk("t5_zero_checks_pass", test_passed, 1);
    chk("t5_zero_checks_count", check_count, 0);

    // ---- Test 7: counters saturate at all-ones instead of wrapping
    do_reset();
    start_test();
    for (int c = 0; c < 17; c++) begin
      drive_all_bad();
      tick();
    end
    chk_valid = '0; tick(); tick();
    chk("t7_check_sat", check_count, 63);
    chk("t7_fail_sat", fail_count, 63);
    chk("t7_first_ch", first_fail_ch, 0);

    // ---- Test 6: idle RUN with watchdog enabled (fires) or disabled (keeps waiting)
    do_reset();
    start_test();
`ifdef TEST_CHECKER_WATCHDOG_EN
    repeat (49) tick();
    chk("t6_wd_not_yet", timeout, 0);
    tick();
    chk("t6_wd_timeout", timeout, 1);
    chk("t6_wd_failed", test_failed, 1);
`else
    repeat (60) tick();
    chk("t6_nowd_timeout", timeout, 0);
    chk("t6_nowd_busy", busy, 1);
    chk("t6_nowd_failed", test_failed, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
